// File: rtl/light_pkg.sv
// Shared types and defaults for the light step controller.
// State encoding: bit0 selects pattern B, bit1 marks a paused state.
package light_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
  localparam int unsigned STEP_DIV_DEF        = 25000000;

  typedef enum logic [1:0] {
    RUN_A   = 2'b00,
    RUN_B   = 2'b01,
    PAUSE_A = 2'b10,
    PAUSE_B = 2'b11
  } state_e;

  // Each press flips its own state bit, so simultaneous presses compose.
  function automatic state_e next_state(input state_e s, input logic mode_press,
                                        input logic pause_press);
    return state_e'(s ^ {pause_press, mode_press});
  endfunction

  function automatic logic is_paused(input state_e s);
    return s[1];
  endfunction

  function automatic logic control_of(input state_e s);
    return ~s[0];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, consecutive-sample debounce and registered press pulse
// for one raw pushbutton.
module btn_debounce
  import light_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned          CntW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0]      CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic            r_level_d;
  logic            r_press;
  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      // The sample that would bring the count to DEBOUNCE_CYCLES flips the level instead.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CntMax) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/light_step_ctrl.sv
// Mode/pause FSM and step divider driving a downstream eight-light pattern stage.
// Both buttons are debounced; the divider runs only in RUN states.
module light_step_ctrl
  import light_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned STEP_DIV        = STEP_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_mode,
  input  logic btn_pause,
  output logic control,
  output logic step,
  output logic paused,
  output logic mode_chg
);

  localparam int unsigned     DivW   = $clog2(STEP_DIV);
  localparam logic [DivW-1:0] DivMax = DivW'(STEP_DIV - 1);

  logic            w_mode_press;
  logic            w_pause_press;
  state_e          w_state_nxt;
  state_e          r_state;
  logic [DivW-1:0] r_div;
  logic            r_control;
  logic            r_paused;
  logic            r_mode_chg;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_mode_db (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_mode),
    .o_press(w_mode_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_pause_db (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_pause),
    .o_press(w_pause_press)
  );

  assign w_state_nxt = next_state(r_state, w_mode_press, w_pause_press);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN_A;
      r_control  <= 1'b1;
      r_paused   <= 1'b0;
      r_mode_chg <= 1'b0;
      r_div      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_control  <= control_of(w_state_nxt);
      r_paused   <= is_paused(w_state_nxt);
      r_mode_chg <= w_mode_press;
      // Clearing on an A/B change keeps step low while mode_chg is high.
      if (w_mode_press) begin
        r_div <= '0;
      end else if (!is_paused(r_state)) begin
        r_div <= (r_div == DivMax) ? '0 : r_div + 1'b1;
      end
    end
  end

  assign step     = !is_paused(r_state) && (r_div == DivMax);
  assign control  = r_control;
  assign paused   = r_paused;
  assign mode_chg = r_mode_chg;

endmodule

// File: doc/light_step_ctrl.md
LIGHT_STEP_CTRL -- requirements
Module: light_step_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, the number of consecutive differing samples needed to accept a new button level (minimum 2).
REQ-002 SHALL have parameter STEP_DIV, default 25000000, the clock cycles per step pulse (minimum 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port btn_mode, input, 1 bit: raw, asynchronous, bouncing mode pushbutton, active-high.
REQ-006 SHALL have port btn_pause, input, 1 bit: raw, asynchronous, bouncing pause pushbutton, active-high.
REQ-007 SHALL have port control, output, 1 bit: pattern-select level for the downstream eight-light pattern stage.
REQ-008 SHALL have port step, output, 1 bit: one-cycle advance strobe for the downstream stage.
REQ-009 SHALL have port paused, output, 1 bit: high while stepping is suspended.
REQ-010 SHALL have port mode_chg, output, 1 bit: one-cycle pulse, high in the first cycle a new control value is presented.

Function
REQ-011 SHALL pass each button through a 2-flop synchronizer before any other use.
REQ-012 Debounce: count consecutive synchronized samples differing from the accepted level; flip the accepted level when the count reaches DEBOUNCE_CYCLES; clear the count on any sample equal to the accepted level.
REQ-013 SHALL produce a registered one-cycle press pulse on each accepted 0->1 transition; 1->0 transitions produce no pulse.
REQ-014 SHALL update control/paused at the (4+DEBOUNCE_CYCLES)th rising edge after a clean button rise.
REQ-015 SHALL implement FSM states RUN_A (control=1), RUN_B (control=0), PAUSE_A (control=1), PAUSE_B (control=0).
REQ-016 Mode press SHALL toggle A<->B and keep run/pause unchanged; pause press SHALL toggle RUN<->PAUSE and keep A/B unchanged.
REQ-017 Mode press and pause press in the same cycle SHALL both apply in one transition (e.g. RUN_A->PAUSE_B).
REQ-018 SHALL drive paused high exactly in the PAUSE_A and PAUSE_B states.
REQ-019 SHALL assert mode_chg for one cycle, coincident with the first cycle control shows its new value.
REQ-020 Step divider: counter 0..STEP_DIV-1, incrementing in RUN states; assert step for the one cycle the counter equals STEP_DIV-1; wrap to 0 on the next edge.
REQ-021 In PAUSE states SHALL hold the divider counter and keep step at 0; on resume SHALL continue from the held count.
REQ-022 On any A/B change SHALL clear the divider to 0, so the first step after the change comes STEP_DIV cycles later.
REQ-023 SHALL generate no step pulse in the same cycle as mode_chg.
REQ-024 SHALL size counters to $clog2 of their parameter and never overflow.

Reset
REQ-025 While reset is high at a clock edge: state=RUN_A, control=1, step=0, paused=0, mode_chg=0; divider, debounce counters, synchronizers and accepted levels all 0.
REQ-026 Reset SHALL take priority over any press or step event in the same cycle.
REQ-027 A button held through reset release SHALL yield exactly one press after debounce.

Structure
REQ-028 Shared package light_pkg SHALL hold the FSM state enum and the default DEBOUNCE_CYCLES/STEP_DIV constants.
REQ-029 Sub-module btn_debounce (synchronizer, debounce counter, press pulse) SHALL be instantiated once per button.

Verification (DEBOUNCE_CYCLES=4, STEP_DIV=5)
REQ-030 Release reset, hold buttons low -> control=1, paused=0; step high on cycles 5, 10 and 15 after reset release; mode_chg never high.
REQ-031 Clean btn_mode rise held 20 cycles -> control 1->0 at edge 8 after the rise, with mode_chg for that one cycle; next step 5 cycles later.
REQ-032 btn_mode glitch high for 3 cycles, repeated -> control unchanged; no mode_chg.
REQ-033 btn_pause press mid-count (counter=2) -> paused=1, no step; second press -> paused=0; step 2 cycles after resume.
REQ-034 Both buttons rise on the same cycle from RUN_A -> single transition to PAUSE_B (control=0, paused=1, mode_chg for one cycle).
REQ-035 Assert reset while in PAUSE_B with the debounce counter mid-count -> RUN_A, control=1, no spurious press after release.
